// File: rtl/xadc_drp_scan_avg.sv
// Multi-channel XADC DRP sampler: on each EOC it reads NUM_CH aux channels,
// averages 2**AVG_LOG2 scans per channel and streams one result per channel.
module xadc_drp_scan_avg #(
    parameter int                  NUM_CH       = 4,
    parameter logic [7*NUM_CH-1:0] CH_ADDR_LIST = {7'h17, 7'h16, 7'h15, 7'h14},
    parameter int                  AVG_LOG2     = 2,
    parameter int                  DATA_W       = 12,
    parameter int                  DRP_TIMEOUT  = 63,
    localparam int                 CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_78MHz_i,
    input  logic              reset_i,
    input  logic              eoc_i,
    output logic              drp_den_o,
    output logic              drp_dwe_o,
    output logic [6:0]        drp_daddr_o,
    output logic [15:0]       drp_di_o,
    input  logic [15:0]       drp_do_i,
    input  logic              drp_drdy_i,
    output logic [DATA_W-1:0] sample_data_o,
    output logic [CH_W-1:0]   sample_ch_o,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              overrun_o,
    output logic              timeout_err_o,
    input  logic              clear_flags_i
);

    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int SCAN_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TO_W   = (DRP_TIMEOUT > 1) ? $clog2(DRP_TIMEOUT + 1) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'((1 << AVG_LOG2) - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(DRP_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, ACC, EMIT} state_t;

    state_t              state_reg, state_next;
    logic [CH_W-1:0]     ch_reg, ch_next;
    logic [CH_W-1:0]     k_reg, k_next;
    logic [SCAN_W-1:0]   scan_reg, scan_next;
    logic [TO_W-1:0]     to_reg, to_next;
    logic [DATA_W-1:0]   cap_reg, cap_next;
    logic                overrun_reg, overrun_next;
    logic                timeout_reg, timeout_next;
    logic                acc_clear, acc_add, timeout_set;
    logic [ACC_W-1:0]    acc_q [NUM_CH];
    logic [ACC_W-1:0]    acc_sel;

    always_comb begin
        state_next  = state_reg;
        ch_next     = ch_reg;
        k_next      = k_reg;
        scan_next   = scan_reg;
        to_next     = to_reg;
        cap_next    = cap_reg;
        acc_clear   = 1'b0;
        acc_add     = 1'b0;
        timeout_set = 1'b0;
        case (state_reg)
            IDLE: begin
                if (eoc_i) begin
                    state_next = REQ;
                    ch_next    = '0;
                end
            end
            REQ: begin
                state_next = WAIT;
                to_next    = '0;
            end
            WAIT: begin
                if (drp_drdy_i) begin
                    cap_next   = drp_do_i[15 -: DATA_W];
                    state_next = ACC;
                end else if (to_reg == TO_LAST) begin
                    // A lost read poisons the whole averaging window, so restart it.
                    timeout_set = 1'b1;
                    acc_clear   = 1'b1;
                    scan_next   = '0;
                    state_next  = IDLE;
                end else begin
                    to_next = to_reg + TO_W'(1);
                end
            end
            ACC: begin
                acc_add = 1'b1;
                if (ch_reg != CH_LAST) begin
                    ch_next    = ch_reg + CH_W'(1);
                    state_next = REQ;
                end else if (scan_reg != SCAN_LAST) begin
                    scan_next  = scan_reg + SCAN_W'(1);
                    state_next = IDLE;
                end else begin
                    k_next     = '0;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (sample_ready_i) begin
                    if (k_reg == CH_LAST) begin
                        acc_clear  = 1'b1;
                        scan_next  = '0;
                        k_next     = '0;
                        state_next = IDLE;
                    end else begin
                        k_next = k_reg + CH_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Set beats clear when both land in the same cycle.
        overrun_next = overrun_reg;
        timeout_next = timeout_reg;
        if (clear_flags_i) begin
            overrun_next = 1'b0;
            timeout_next = 1'b0;
        end
        if (eoc_i && (state_reg != IDLE)) overrun_next = 1'b1;
        if (timeout_set) timeout_next = 1'b1;
    end

    always_ff @(posedge clk_78MHz_i) begin
        if (reset_i) begin
            state_reg   <= IDLE;
            ch_reg      <= '0;
            k_reg       <= '0;
            scan_reg    <= '0;
            to_reg      <= '0;
            cap_reg     <= '0;
            overrun_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ch_reg      <= ch_next;
            k_reg       <= k_next;
            scan_reg    <= scan_next;
            to_reg      <= to_next;
            cap_reg     <= cap_next;
            overrun_reg <= overrun_next;
            timeout_reg <= timeout_next;
        end
    end

    // Per-channel accumulators are wide enough for 2**AVG_LOG2 full-scale samples.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_acc
        logic [ACC_W-1:0] acc_reg;
        always_ff @(posedge clk_78MHz_i) begin
            if (reset_i || acc_clear) begin
                acc_reg <= '0;
            end else if (acc_add && (ch_reg == CH_W'(gi))) begin
                acc_reg <= acc_reg + ACC_W'(cap_reg);
            end
        end
        assign acc_q[gi] = acc_reg;
    end

    if (DATA_W < 16) begin : g_unused_low
        logic unused_do_low;
        assign unused_do_low = ^drp_do_i[15-DATA_W:0];
    end

    assign acc_sel = acc_q[k_reg];

    assign drp_den_o      = (state_reg == REQ);
    assign drp_dwe_o      = 1'b0;
    assign drp_di_o       = '0;
    assign drp_daddr_o    = ((state_reg == REQ) || (state_reg == WAIT)) ?
                            CH_ADDR_LIST[7*int'(ch_reg) +: 7] : 7'd0;
    assign sample_valid_o = (state_reg == EMIT);
    assign sample_ch_o    = (state_reg == EMIT) ? k_reg : '0;
    assign sample_data_o  = (state_reg == EMIT) ? acc_sel[ACC_W-1:AVG_LOG2] : '0;
    assign overrun_o      = overrun_reg;
    assign timeout_err_o  = timeout_reg;

endmodule

// File: tb/tb_xadc_drp_scan_avg.sv
// Directed bench for xadc_drp_scan_avg: a DRP responder, a scan-level averaging
// model with expected-address and expected-sample queues, and per-cycle compare.
module tb_xadc_drp_scan_avg;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        eoc_a = 1'b0, eoc_b = 1'b0;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;
    logic        ready = 1'b1;
    logic        clear_flags = 1'b0;

    logic        den_a, dwe_a, valid_a, ovr_a, to_a;
    logic [6:0]  daddr_a;
    logic [15:0] di_a;
    logic [11:0] data_a;
    logic [1:0]  ch_a;

    logic        den_b, dwe_b, valid_b, ovr_b, to_b;
    logic [6:0]  daddr_b;
    logic [15:0] di_b;
    logic [11:0] data_b;
    logic [1:0]  ch_b;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit drp_mute = 1'b0;

    logic [11:0] resp_val [4];
    logic [6:0]  addr_q_a[$], addr_q_b[$];
    logic [13:0] exp_q_a[$], exp_q_b[$];
    int          sum_b [4];
    int          scans_b = 0;
    logic [11:0] last_a [4];
    logic [11:0] last_b [4];
    int          acc_cyc_a [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xadc_drp_scan_avg #(.AVG_LOG2(0)) dut_a (
        .clk_78MHz_i(clk), .reset_i(reset_i), .eoc_i(eoc_a),
        .drp_den_o(den_a), .drp_dwe_o(dwe_a), .drp_daddr_o(daddr_a), .drp_di_o(di_a),
        .drp_do_i(drp_do), .drp_drdy_i(drp_drdy),
        .sample_data_o(data_a), .sample_ch_o(ch_a), .sample_valid_o(valid_a),
        .sample_ready_i(ready), .overrun_o(ovr_a), .timeout_err_o(to_a),
        .clear_flags_i(clear_flags)
    );

    xadc_drp_scan_avg #(.AVG_LOG2(2)) dut_b (
        .clk_78MHz_i(clk), .reset_i(reset_i), .eoc_i(eoc_b),
        .drp_den_o(den_b), .drp_dwe_o(dwe_b), .drp_daddr_o(daddr_b), .drp_di_o(di_b),
        .drp_do_i(drp_do), .drp_drdy_i(drp_drdy),
        .sample_data_o(data_b), .sample_ch_o(ch_b), .sample_valid_o(valid_b),
        .sample_ready_i(ready), .overrun_o(ovr_b), .timeout_err_o(to_b),
        .clear_flags_i(clear_flags)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the AVG_LOG2=0 instance echoes each scan; the other averages four.
    task automatic model_scan_a;
        for (int k = 0; k < 4; k++) exp_q_a.push_back({2'(k), resp_val[k]});
    endtask

    task automatic model_scan_b;
        for (int k = 0; k < 4; k++) sum_b[k] += int'(resp_val[k]);
        scans_b++;
        if (scans_b == 4) begin
            for (int k = 0; k < 4; k++) begin
                exp_q_b.push_back({2'(k), 12'(sum_b[k] / 4)});
                sum_b[k] = 0;
            end
            scans_b = 0;
        end
    endtask

    task automatic model_discard_b;
        for (int k = 0; k < 4; k++) sum_b[k] = 0;
        scans_b = 0;
    endtask

    task automatic run_scan(input bit on_a, input logic [11:0] v0, input logic [11:0] v1,
                            input logic [11:0] v2, input logic [11:0] v3, input int post);
        resp_val[0] = v0; resp_val[1] = v1; resp_val[2] = v2; resp_val[3] = v3;
        for (int k = 0; k < 4; k++) begin
            if (on_a) addr_q_a.push_back(7'(20 + k));
            else      addr_q_b.push_back(7'(20 + k));
        end
        if (on_a) model_scan_a(); else model_scan_b();
        @(negedge clk);
        if (on_a) eoc_a = 1'b1; else eoc_b = 1'b1;
        @(negedge clk);
        eoc_a = 1'b0; eoc_b = 1'b0;
        repeat (post) @(negedge clk);
    endtask

    // DRP responder: drdy with table data three cycles after each den.
    initial begin
        forever begin
            @(negedge clk);
            if ((den_a || den_b) && !drp_mute) begin
                int c;
                c = int'(den_a ? daddr_a : daddr_b) - 20;
                if (c < 0 || c > 3) c = 0;
                repeat (3) @(negedge clk);
                drp_do   = {resp_val[c], 4'h0};
                drp_drdy = 1'b1;
                @(negedge clk);
                drp_drdy = 1'b0;
                drp_do   = '0;
            end
        end
    end

    // Per-cycle compare of DRP addresses and stream samples against the queues.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (den_a) begin
                if (addr_q_a.size() == 0) check("a_den_unexpected", 32'(den_a), 32'd0);
                else check("a_daddr", 32'(daddr_a), 32'(addr_q_a.pop_front()));
            end
            if (den_b) begin
                if (addr_q_b.size() == 0) check("b_den_unexpected", 32'(den_b), 32'd0);
                else check("b_daddr", 32'(daddr_b), 32'(addr_q_b.pop_front()));
            end
            if (valid_a) begin
                if (exp_q_a.size() == 0) check("a_valid_unexpected", 32'(valid_a), 32'd0);
                else begin
                    check("a_sample", 32'({ch_a, data_a}), 32'(exp_q_a[0]));
                    if (ready) begin
                        last_a[ch_a] = data_a;
                        acc_cyc_a[ch_a] = cyc;
                        void'(exp_q_a.pop_front());
                    end
                end
            end
            if (valid_b) begin
                if (exp_q_b.size() == 0) check("b_valid_unexpected", 32'(valid_b), 32'd0);
                else begin
                    check("b_sample", 32'({ch_b, data_b}), 32'(exp_q_b[0]));
                    if (ready) begin
                        last_b[ch_b] = data_b;
                        void'(exp_q_b.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        for (int k = 0; k < 4; k++) begin
            resp_val[k] = '0; sum_b[k] = 0; last_a[k] = '0; last_b[k] = '0; acc_cyc_a[k] = 0;
        end
        repeat (3) @(negedge clk);
        reset_i = 1'b0;

        // Reset state
        check("rst_den", 32'(den_b), 0);
        check("rst_daddr", 32'(daddr_b), 0);
        check("rst_valid", 32'({valid_a, valid_b}), 0);
        check("rst_data_ch", 32'({ch_b, data_b}), 0);
        check("rst_flags", 32'({ovr_b, to_b}), 0);
        check("rst_dwe_di", 32'({dwe_b, di_b}), 0);

        // 1: no averaging, one scan streams back-to-back
        run_scan(1'b1, 12'h100, 12'h101, 12'h102, 12'h103, 28);
        check("a_ch0_literal", 32'(last_a[0]), 32'h100);
        check("a_ch3_literal", 32'(last_a[3]), 32'h103);
        check("a_back_to_back", 32'(acc_cyc_a[3] - acc_cyc_a[0]), 32'd3);

        // 2: four-scan average with truncation
        run_scan(1'b0, 12'h100, 12'h7ff, 12'h001, 12'hfff, 28);
        run_scan(1'b0, 12'h101, 12'h7ff, 12'h001, 12'hfff, 28);
        run_scan(1'b0, 12'h102, 12'h7ff, 12'h001, 12'hfff, 28);
        run_scan(1'b0, 12'h105, 12'h7ff, 12'h001, 12'hfff, 28);
        check("b_avg_literal", 32'(last_b[0]), 32'h102);
        check("b_fullscale_literal", 32'(last_b[3]), 32'hfff);
        run_scan(1'b0, 12'h100, 12'h010, 12'h020, 12'h030, 28);
        run_scan(1'b0, 12'h100, 12'h011, 12'h020, 12'h030, 28);
        run_scan(1'b0, 12'h100, 12'h012, 12'h021, 12'h030, 28);
        run_scan(1'b0, 12'h103, 12'h013, 12'h021, 12'h031, 28);
        check("b_trunc_literal", 32'(last_b[0]), 32'h100);

        // 3: backpressure in EMIT, EOC during EMIT is an overrun with no read
        for (int i = 0; i < 3; i++)
            run_scan(1'b0, 12'(12'h400 + i), 12'(12'h410 + i), 12'(12'h420 + i), 12'(12'h430 + i), 28);
        ready = 1'b0;
        run_scan(1'b0, 12'h403, 12'h413, 12'h423, 12'h433, 22);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) eoc_b = 1'b1;
            if (i == 4) eoc_b = 1'b0;
        end
        check("bp_valid_held", 32'(valid_b), 1);
        check("bp_overrun", 32'(ovr_b), 1);
        ready = 1'b1;
        repeat (10) @(negedge clk);

        // 4: DRP timeout discards the partial window
        run_scan(1'b0, 12'h800, 12'h800, 12'h800, 12'h800, 28);
        run_scan(1'b0, 12'h800, 12'h800, 12'h800, 12'h800, 28);
        drp_mute = 1'b1;
        addr_q_b.push_back(7'h14);
        model_discard_b();
        @(negedge clk); eoc_b = 1'b1;
        @(negedge clk); eoc_b = 1'b0;
        n = 0;
        while (!den_b && n < 10) begin @(negedge clk); n++; end
        t0 = cyc;
        n = 0;
        while (!to_b && n < 200) begin @(negedge clk); n++; end
        check("timeout_flag", 32'(to_b), 1);
        check("timeout_delay", 32'(cyc - t0), 32'd64);
        drp_mute = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++)
            run_scan(1'b0, 12'h100, 12'h101, 12'h102, 12'h103, 28);
        check("timeout_avg_literal", 32'(last_b[1]), 32'h101);

        // 6: clear with simultaneous overrun: set wins; clear alone clears both
        resp_val[0] = 12'h050; resp_val[1] = 12'h060; resp_val[2] = 12'h070; resp_val[3] = 12'h080;
        for (int k = 0; k < 4; k++) addr_q_b.push_back(7'(20 + k));
        model_scan_b();
        @(negedge clk); eoc_b = 1'b1;
        @(negedge clk); eoc_b = 1'b0;
        repeat (2) @(negedge clk);
        eoc_b = 1'b1; clear_flags = 1'b1;
        @(negedge clk);
        eoc_b = 1'b0; clear_flags = 1'b0;
        check("clr_set_wins_ovr", 32'(ovr_b), 1);
        check("clr_timeout", 32'(to_b), 0);
        @(negedge clk); clear_flags = 1'b1;
        @(negedge clk); clear_flags = 1'b0;
        check("clr_flags_both", 32'({ovr_b, to_b}), 0);
        repeat (24) @(negedge clk);

        // 5: reset while waiting on ch2
        resp_val[0] = 12'h0aa; resp_val[1] = 12'h0bb; resp_val[2] = 12'h0cc; resp_val[3] = 12'h0dd;
        for (int k = 0; k < 3; k++) addr_q_b.push_back(7'(20 + k));
        @(negedge clk); eoc_b = 1'b1;
        @(negedge clk); eoc_b = 1'b0;
        @(negedge clk); eoc_b = 1'b1;
        @(negedge clk); eoc_b = 1'b0;
        check("rst5_overrun_pre", 32'(ovr_b), 1);
        n = 0;
        while (!(den_b && daddr_b == 7'h16) && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        check("rst5_wait_daddr", 32'(daddr_b), 32'h16);
        reset_i = 1'b1;
        @(negedge clk);
        check("rst5_den", 32'(den_b), 0);
        check("rst5_daddr", 32'(daddr_b), 0);
        check("rst5_stream", 32'({valid_b, ch_b, data_b}), 0);
        check("rst5_flags", 32'({ovr_b, to_b}), 0);
        reset_i = 1'b0;
        model_discard_b();
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++)
            run_scan(1'b0, 12'(12'h300 + i), 12'(12'h304 + i), 12'(12'h308 + i), 12'(12'h30c + i), 28);
        check("rst5_avg_literal", 32'(last_b[2]), 32'h309);

        check("a_samples_left", 32'(exp_q_a.size()), 0);
        check("b_samples_left", 32'(exp_q_b.size()), 0);
        check("b_reads_left", 32'(addr_q_b.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
